// File: rtl/maze_pkg.sv
// Shared maze encodings: move commands, headings and the
// player-controller FSM states used by the renderer overlay.
package maze_pkg;

  typedef enum logic [1:0] {
    CMD_NONE     = 2'd0,
    CMD_STRAIGHT = 2'd1,
    CMD_LEFT     = 2'd2,
    CMD_RIGHT    = 2'd3
  } cmd_e;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_e;

  // Heading rotation wraps naturally in two bits.
  function automatic logic [1:0] turn_dir(
    input logic [1:0] d,
    input logic       right
  );
    return right ? d + 2'd1 : d - 2'd1;
  endfunction

endpackage

// File: rtl/maze_player_ctrl_if.sv
// Player controller bus: keyboard command, wall-map read
// port and the position/status outputs.
interface maze_player_ctrl_if #(
  parameter int MAZE_W = 16,
  parameter int MAZE_H = 16
);
  localparam int XW = $clog2(MAZE_W);
  localparam int YW = $clog2(MAZE_H);
  localparam int AW = XW + YW;

  logic [1:0]    cmd;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_wall;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic [1:0]    dir;
  logic          move_pulse;
  logic          bump_pulse;
  logic          goal;

  modport master (
    input  cmd, mem_wall,
    output mem_rd, mem_addr, pos_x, pos_y,
    output dir, move_pulse, bump_pulse, goal
  );

  modport slave (
    output cmd, mem_wall,
    input  mem_rd, mem_addr, pos_x, pos_y,
    input  dir, move_pulse, bump_pulse, goal
  );
endinterface

// File: rtl/maze_next_cell.sv
// Target cell one step ahead of the player, with a flag
// for stepping off the maze edge.
module maze_next_cell
  import maze_pkg::*;
#(
  parameter int MAZE_W = 16,
  parameter int MAZE_H = 16,
  localparam int XW = $clog2(MAZE_W),
  localparam int YW = $clog2(MAZE_H)
) (
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  logic [1:0]    i_dir,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_oob
);

  localparam logic [XW-1:0] X_MAX = XW'(MAZE_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(MAZE_H - 1);

  // Offset by heading; edge cells flag out of bounds.
  always_comb begin
    o_x   = i_x;
    o_y   = i_y;
    o_oob = 1'b0;
    unique case (i_dir)
      DIR_N: begin
        o_y   = i_y - 1'b1;
        o_oob = (i_y == '0);
      end
      DIR_E: begin
        o_x   = i_x + 1'b1;
        o_oob = (i_x == X_MAX);
      end
      DIR_S: begin
        o_y   = i_y + 1'b1;
        o_oob = (i_y == Y_MAX);
      end
      default: begin
        o_x   = i_x - 1'b1;
        o_oob = (i_x == '0);
      end
    endcase
  end

endmodule

// File: rtl/maze_player_ctrl.sv
// Maze player controller: turns, wall-checked steps,
// post-action lockout and sticky goal detection.
module maze_player_ctrl
  import maze_pkg::*;
#(
  parameter int MAZE_W     = 16,
  parameter int MAZE_H     = 16,
  parameter int START_X    = 0,
  parameter int START_Y    = 0,
  parameter int START_DIR  = 0,
  parameter int GOAL_X     = 15,
  parameter int GOAL_Y     = 15,
  parameter int GAP_CYCLES = 5000000
) (
  input logic              clk,
  input logic              rst,
  maze_player_ctrl_if.master bus
);

  localparam int XW = $clog2(MAZE_W);
  localparam int YW = $clog2(MAZE_H);
  localparam int AW = XW + YW;
  localparam int CW = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  state_e        r_state;
  state_e        w_next;
  logic [1:0]    r_cmd_q;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [1:0]    r_dir;
  logic [XW-1:0] r_tx;
  logic [YW-1:0] r_ty;
  logic          r_rd;
  logic [AW-1:0] r_addr;
  logic          r_move;
  logic          r_bump;
  logic          r_goal;
  logic [CW-1:0] r_gap;

  logic          w_event;
  logic          w_hit_goal;
  logic [XW-1:0] w_tx;
  logic [YW-1:0] w_ty;
  logic          w_oob;

  maze_next_cell #(
    .MAZE_W (MAZE_W),
    .MAZE_H (MAZE_H)
  ) u_next (
    .i_x   (r_x),
    .i_y   (r_y),
    .i_dir (r_dir),
    .o_x   (w_tx),
    .o_y   (w_ty),
    .o_oob (w_oob)
  );

  assign w_event = (bus.cmd != CMD_NONE) &&
                   (bus.cmd != r_cmd_q);

  assign w_hit_goal = (r_tx == XW'(GOAL_X)) &&
                      (r_ty == YW'(GOAL_Y));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: straight in bounds reads the map, others lock out.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_event) begin
          if (bus.cmd == CMD_STRAIGHT && !w_oob)
            w_next = ST_RD;
          else
            w_next = ST_GAP;
        end
      end
      ST_RD:   w_next = ST_WAIT;
      ST_WAIT: begin
        if (!bus.mem_wall && w_hit_goal)
          w_next = ST_DONE;
        else
          w_next = ST_GAP;
      end
      ST_GAP:  if (r_gap == '0) w_next = ST_IDLE;
      ST_DONE: w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Position, heading, read port, pulses and goal flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_q <= '0;
      r_x     <= XW'(START_X);
      r_y     <= YW'(START_Y);
      r_dir   <= 2'(START_DIR);
      r_tx    <= '0;
      r_ty    <= '0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_move  <= 1'b0;
      r_bump  <= 1'b0;
      r_goal  <= 1'b0;
    end else begin
      r_cmd_q <= bus.cmd;
      r_rd    <= 1'b0;
      r_move  <= 1'b0;
      r_bump  <= 1'b0;
      if (r_state == ST_IDLE && w_event) begin
        unique case (bus.cmd)
          CMD_LEFT:  r_dir <= turn_dir(r_dir, 1'b0);
          CMD_RIGHT: r_dir <= turn_dir(r_dir, 1'b1);
          default: begin
            if (w_oob) begin
              r_bump <= 1'b1;
            end else begin
              r_rd   <= 1'b1;
              r_addr <= {w_ty, w_tx};
              r_tx   <= w_tx;
              r_ty   <= w_ty;
            end
          end
        endcase
      end
      if (r_state == ST_WAIT) begin
        if (bus.mem_wall) begin
          r_bump <= 1'b1;
        end else begin
          r_x    <= r_tx;
          r_y    <= r_ty;
          r_move <= 1'b1;
          if (w_hit_goal) r_goal <= 1'b1;
        end
      end
    end
  end

  // Lockout counter: load on GAP entry, count down inside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap <= '0;
    end else if (w_next == ST_GAP && r_state != ST_GAP) begin
      r_gap <= GAP_LOAD;
    end else if (r_state == ST_GAP && r_gap != '0) begin
      r_gap <= r_gap - 1'b1;
    end
  end

  assign bus.mem_rd     = r_rd;
  assign bus.mem_addr   = r_addr;
  assign bus.pos_x      = r_x;
  assign bus.pos_y      = r_y;
  assign bus.dir        = r_dir;
  assign bus.move_pulse = r_move;
  assign bus.bump_pulse = r_bump;
  assign bus.goal       = r_goal;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Bench for maze_player_ctrl: directed scenarios plus random
// commands against a cycle-scheduled behavioural model.
module tb_maze_player_ctrl;

  localparam int W   = 16;
  localparam int H   = 16;
  localparam int GAP = 4;
  localparam int GX  = 15;
  localparam int GY  = 15;

  logic clk = 1'b0;
  logic rst;

  always #10 clk = ~clk;

  maze_player_ctrl_if #(.MAZE_W(W), .MAZE_H(H)) bus ();

  maze_player_ctrl #(
    .MAZE_W     (W),
    .MAZE_H     (H),
    .START_X    (0),
    .START_Y    (0),
    .START_DIR  (0),
    .GOAL_X     (GX),
    .GOAL_Y     (GY),
    .GAP_CYCLES (GAP)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic wallmap [W*H];

  // Wall-map RAM with one cycle of read latency.
  always @(posedge clk or posedge rst) begin
    if (rst)             bus.mem_wall <= 1'b0;
    else if (bus.mem_rd) bus.mem_wall <= wallmap[bus.mem_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  int         m_x, m_y, m_dir, m_addr;
  int         m_tx, m_ty, m_wait, m_ready;
  bit         m_goal, m_move, m_bump, m_rd;
  bit         m_done, m_pend;
  logic [1:0] m_prev;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dir = 0; m_addr = 0;
    m_goal = 0; m_move = 0; m_bump = 0; m_rd = 0;
    m_done = 0; m_pend = 0; m_ready = 0; m_prev = 2'd0;
  endtask

  task automatic compare();
    chk("pos_x", 32'(bus.pos_x), m_x);
    chk("pos_y", 32'(bus.pos_y), m_y);
    chk("dir", 32'(bus.dir), m_dir);
    chk("mem_rd", 32'(bus.mem_rd), 32'(m_rd));
    chk("mem_addr", 32'(bus.mem_addr), m_addr);
    chk("move_pulse", 32'(bus.move_pulse), 32'(m_move));
    chk("bump_pulse", 32'(bus.bump_pulse), 32'(m_bump));
    chk("goal", 32'(bus.goal), 32'(m_goal));
  endtask

  // Predict outputs of the next cycle from command c in cycle cyc.
  task automatic model_step(logic [1:0] c);
    bit ev;
    int nx, ny;
    ev = (c != 2'd0) && (c != m_prev);
    m_prev = c;
    m_move = 0; m_bump = 0; m_rd = 0;
    if (m_pend && cyc == m_wait) begin
      m_pend = 0;
      if (wallmap[m_ty*W + m_tx]) begin
        m_bump = 1;
      end else begin
        m_x = m_tx; m_y = m_ty; m_move = 1;
        if (m_x == GX && m_y == GY) begin
          m_goal = 1; m_done = 1;
        end
      end
      m_ready = cyc + 1 + GAP;
    end else if (!m_done && !m_pend && cyc >= m_ready && ev) begin
      if (c == 2'd2) begin
        m_dir = (m_dir + 3) % 4;
        m_ready = cyc + 1 + GAP;
      end else if (c == 2'd3) begin
        m_dir = (m_dir + 1) % 4;
        m_ready = cyc + 1 + GAP;
      end else begin
        nx = m_x; ny = m_y;
        case (m_dir)
          0: ny = m_y - 1;
          1: nx = m_x + 1;
          2: ny = m_y + 1;
          default: nx = m_x - 1;
        endcase
        if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
          m_bump = 1;
          m_ready = cyc + 1 + GAP;
        end else begin
          m_rd = 1; m_addr = ny*W + nx;
          m_tx = nx; m_ty = ny;
          m_pend = 1; m_wait = cyc + 2;
        end
      end
    end
  endtask

  task automatic run(logic [1:0] c);
    bus.cmd = c;
    model_step(c);
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  task automatic press(logic [1:0] c, int idle);
    run(c);
    repeat (idle) run(2'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd = 2'd0;
    model_reset();
    #3;
    compare();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
    compare();
  endtask

  task automatic clear_walls();
    for (int i = 0; i < W*H; i++) wallmap[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd = 2'd0;
    clear_walls();

    // Held right key turns once; release then right turns again.
    do_reset();
    repeat (6) run(2'd3);
    repeat (2) run(2'd0);
    repeat (6) run(2'd3);
    chk("dir_two_turns", 32'(bus.dir), 2);

    // Open step east from (0,0).
    do_reset();
    press(2'd3, GAP + 2);
    run(2'd1);
    chk("step_rd_t1", 32'(bus.mem_rd), 1);
    chk("step_addr_t1", 32'(bus.mem_addr), 1);
    run(2'd0);
    run(2'd0);
    chk("step_pos_t3", 32'(bus.pos_x), 1);
    chk("step_move_t3", 32'(bus.move_pulse), 1);
    repeat (GAP + 2) run(2'd0);

    // Walled step east bumps at T+3.
    do_reset();
    wallmap[1] = 1'b1;
    press(2'd3, GAP + 2);
    run(2'd1);
    run(2'd0);
    run(2'd0);
    chk("wall_bump_t3", 32'(bus.bump_pulse), 1);
    chk("wall_pos_x", 32'(bus.pos_x), 0);
    repeat (GAP + 2) run(2'd0);
    wallmap[1] = 1'b0;

    // Edge bump facing north at (0,0), no read.
    do_reset();
    run(2'd1);
    chk("edge_bump_t1", 32'(bus.bump_pulse), 1);
    chk("edge_no_rd", 32'(bus.mem_rd), 0);
    repeat (GAP + 2) run(2'd0);

    // Keys changed during lockout are dropped and not replayed.
    do_reset();
    run(2'd3);
    run(2'd2);
    run(2'd3);
    run(2'd0);
    run(2'd1);
    repeat (4) run(2'd1);
    chk("gap_dropped_dir", 32'(bus.dir), 1);
    chk("gap_dropped_y", 32'(bus.pos_y), 0);
    press(2'd2, GAP + 2);
    chk("after_gap_left", 32'(bus.dir), 0);

    // Walk to the goal; later commands are ignored.
    do_reset();
    press(2'd3, GAP + 2);
    repeat (15) press(2'd1, GAP + 4);
    press(2'd3, GAP + 2);
    repeat (14) press(2'd1, GAP + 4);
    run(2'd1);
    run(2'd0);
    run(2'd0);
    chk("goal_move", 32'(bus.move_pulse), 1);
    chk("goal_flag", 32'(bus.goal), 1);
    for (int i = 0; i < 40; i++) run(2'($urandom_range(0, 3)));
    chk("goal_frozen_x", 32'(bus.pos_x), GX);
    chk("goal_frozen_y", 32'(bus.pos_y), GY);

    // Reset during WAIT restores the start state immediately.
    do_reset();
    press(2'd3, GAP + 2);
    run(2'd1);
    run(2'd0);
    #4;
    rst = 1'b1;
    #1;
    chk("rst_wait_x", 32'(bus.pos_x), 0);
    chk("rst_wait_dir", 32'(bus.dir), 0);
    chk("rst_wait_rd", 32'(bus.mem_rd), 0);
    chk("rst_wait_addr", 32'(bus.mem_addr), 0);
    chk("rst_wait_move", 32'(bus.move_pulse), 0);
    do_reset();

    // Random walk over a random wall map.
    for (int i = 0; i < W*H; i++)
      wallmap[i] = ($urandom_range(0, 3) == 0);
    do_reset();
    for (int i = 0; i < 120; i++) begin
      logic [1:0] c;
      int hold;
      c = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 10);
      repeat (hold) run(c);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
